// File: rtl/prbs31_test_sequencer.sv
// prbs31_test_sequencer
//   Per-lane PRBS31 (x^31 + x^28 + 1) link-test sequencer. Seeds and runs the
//   transmit generator, self-synchronises the receive checker, tracks lock and
//   loss-of-lock, and counts checked bits and errors over a programmed length.
//   Optional feature macro: ERR_INJECT_EN adds the 'inject' input, which flips
//   tx_bit for one cycle while the test is running.
//   rst_n is the block's asynchronous reset and is active HIGH.
module prbs31_test_sequencer #(
  parameter int unsigned SYNC_LEN = 31,
  parameter int unsigned LOSS_THR = 8,
  parameter int unsigned ERR_W    = 16,
  parameter int unsigned LEN_W    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] test_len,
  input  logic             rx_bit,
  input  logic             rx_valid,
`ifdef ERR_INJECT_EN
  input  logic             inject,
`endif
  output logic             tx_bit,
  output logic             tx_valid,
  output logic [1:0]       state,
  output logic             locked,
  output logic             los,
  output logic [LEN_W-1:0] bit_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOCK = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Feedback tap shared by generator and checker: x^31 + x^28 + 1.
  function automatic logic prbs_fb(input logic [30:0] s);
    return s[27] ^ s[30];
  endfunction

  state_e           state_r;
  logic [30:0]      gen_r;
  logic [30:0]      chk_r;
  logic [4:0]       fill_r;
  logic [7:0]       run_r;
  logic [7:0]       miss_r;
  logic [LEN_W-1:0] bit_cnt_r;
  logic [ERR_W-1:0] err_cnt_r;
  logic             los_r;
  logic             tx_bit_r;
  logic             tx_valid_r;
  logic             locked_r;

  state_e           state_nxt_s;
  logic [30:0]      gen_nxt_s;
  logic             active_s;
  logic             start_acc_s;
  logic             rx_upd_s;
  logic             filled_s;
  logic             match_s;
  logic             sync_hit_s;
  logic             miss_hit_s;
  logic             done_hit_s;
  logic             inj_s;
  logic [LEN_W:0]   bit_p1_s;

  // Checker decode, start qualification and generator next-state.
  always_comb begin
    active_s    = (state_r == ST_SYNC) || (state_r == ST_LOCK);
    start_acc_s = start && !stop && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    // stop freezes the checker and counters in the cycle it is seen
    rx_upd_s    = rx_valid && active_s && !stop;
    filled_s    = (fill_r == 5'd31);
    match_s     = (rx_bit == prbs_fb(chk_r));
    sync_hit_s  = filled_s && match_s && (run_r == 8'(SYNC_LEN - 1));
    miss_hit_s  = !match_s && (miss_r == 8'(LOSS_THR - 1));
    bit_p1_s    = {1'b0, bit_cnt_r} + {{LEN_W{1'b0}}, 1'b1};
    done_hit_s  = (test_len != {LEN_W{1'b0}}) && (bit_p1_s == {1'b0, test_len});
`ifdef ERR_INJECT_EN
    inj_s       = inject && active_s && !stop;
`else
    inj_s       = 1'b0;
`endif
    if (start_acc_s) begin
      gen_nxt_s = 31'd1;
    end else if (tx_valid_r) begin
      gen_nxt_s = {gen_r[29:0], prbs_fb(gen_r)};
    end else begin
      gen_nxt_s = gen_r;
    end
  end

  // Next-state selection; stop overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (stop) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_nxt_s = ST_SYNC;
          else       state_nxt_s = ST_IDLE;
        end
        ST_SYNC: begin
          if (rx_upd_s && sync_hit_s) state_nxt_s = ST_LOCK;
          else                        state_nxt_s = ST_SYNC;
        end
        ST_LOCK: begin
          // loss of lock wins over end-of-test on the same bit
          if (rx_upd_s && miss_hit_s)      state_nxt_s = ST_SYNC;
          else if (rx_upd_s && done_hit_s) state_nxt_s = ST_DONE;
          else                             state_nxt_s = ST_LOCK;
        end
        ST_DONE: begin
          if (start) state_nxt_s = ST_SYNC;
          else       state_nxt_s = ST_DONE;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Sequencer state, generator/checker shift registers, counters and registered outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r    <= ST_IDLE;
      gen_r      <= 31'd1;
      chk_r      <= 31'd0;
      fill_r     <= 5'd0;
      run_r      <= 8'd0;
      miss_r     <= 8'd0;
      bit_cnt_r  <= {LEN_W{1'b0}};
      err_cnt_r  <= {ERR_W{1'b0}};
      los_r      <= 1'b0;
      tx_bit_r   <= 1'b0;
      tx_valid_r <= 1'b0;
      locked_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      gen_r      <= gen_nxt_s;
      tx_bit_r   <= gen_nxt_s[30] ^ inj_s;
      tx_valid_r <= (state_nxt_s == ST_SYNC) || (state_nxt_s == ST_LOCK);
      locked_r   <= (state_nxt_s == ST_LOCK);
      if (start_acc_s) begin
        chk_r     <= 31'd0;
        fill_r    <= 5'd0;
        run_r     <= 8'd0;
        miss_r    <= 8'd0;
        bit_cnt_r <= {LEN_W{1'b0}};
        err_cnt_r <= {ERR_W{1'b0}};
        los_r     <= 1'b0;
      end else if (rx_upd_s) begin
        chk_r <= {chk_r[29:0], rx_bit};
        if (!filled_s) begin
          fill_r <= fill_r + 5'd1;
        end else if (state_r == ST_SYNC) begin
          if (match_s && !sync_hit_s) run_r <= run_r + 8'd1;
          else                        run_r <= 8'd0;
        end else begin
          if (!(&bit_cnt_r)) bit_cnt_r <= bit_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
          if (match_s) begin
            miss_r <= 8'd0;
          end else begin
            if (!(&err_cnt_r)) err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
            if (miss_hit_s) begin
              miss_r <= 8'd0;
              fill_r <= 5'd0;
              run_r  <= 8'd0;
              los_r  <= 1'b1;
            end else begin
              miss_r <= miss_r + 8'd1;
            end
          end
        end
      end
    end
  end

  assign tx_bit   = tx_bit_r;
  assign tx_valid = tx_valid_r;
  assign state    = state_r;
  assign locked   = locked_r;
  assign los      = los_r;
  assign bit_cnt  = bit_cnt_r;
  assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_prbs31_test_sequencer.sv
// tb_prbs31_test_sequencer
//   Directed loopback bench for prbs31_test_sequencer. tx is looped to rx with an
//   optional single-bit flip; expectations are queued when stimulus is driven and
//   popped when the outputs are sampled on the falling clock edge.
//   Build with ERR_INJECT_EN defined to exercise the inject port.
module tb_prbs31_test_sequencer;

  localparam int LEN_W = 24;
  localparam int ERR_W = 16;
`ifdef ERR_INJECT_EN
  localparam int INJ = 1;
`else
  localparam int INJ = 0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic [LEN_W-1:0] test_len;
  logic             rx_bit;
  logic             rx_valid;
  logic             flip;
`ifdef ERR_INJECT_EN
  logic             inject;
`endif
  logic             tx_bit;
  logic             tx_valid;
  logic [1:0]       state;
  logic             locked;
  logic             los;
  logic [LEN_W-1:0] bit_cnt;
  logic [ERR_W-1:0] err_cnt;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // Loopback with an optional inverted bit.
  assign rx_bit   = tx_bit ^ flip;
  assign rx_valid = tx_valid;

  prbs31_test_sequencer #(
    .SYNC_LEN(31), .LOSS_THR(8), .ERR_W(ERR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .test_len(test_len),
    .rx_bit(rx_bit),
    .rx_valid(rx_valid),
`ifdef ERR_INJECT_EN
    .inject(inject),
`endif
    .tx_bit(tx_bit),
    .tx_valid(tx_valid),
    .state(state),
    .locked(locked),
    .los(los),
    .bit_cnt(bit_cnt),
    .err_cnt(err_cnt)
  );

  task automatic expect_v(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic flip_one();
    flip = 1'b1;
    cyc(1);
    flip = 1'b0;
  endtask

  // Runaway guard.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Directed sequence.
  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    flip     = 1'b0;
    test_len = '0;
`ifdef ERR_INJECT_EN
    inject   = 1'b0;
`endif
    cyc(2);
    rst_n = 1'b0;

    // Reset state
    expect_v("rst_state", 0); expect_v("rst_tx_valid", 0); expect_v("rst_tx_bit", 0);
    expect_v("rst_err", 0);   expect_v("rst_bits", 0);     expect_v("rst_los", 0);
    cyc(1);
    check_v(32'(state)); check_v(32'(tx_valid)); check_v(32'(tx_bit));
    check_v(32'(err_cnt)); check_v(32'(bit_cnt)); check_v(32'(los));

    // Test 1: clean loopback, 1000-bit test; lock after 31 fill + 31 matches
    test_len = 24'd1000;
    expect_v("t1_sync", 1); expect_v("t1_tx_valid", 1);
    pulse_start();
    check_v(32'(state)); check_v(32'(tx_valid));
    expect_v("t1_sync_61", 1);
    cyc(61);
    check_v(32'(state));
    expect_v("t1_lock_62", 2); expect_v("t1_locked", 1); expect_v("t1_bits0", 0);
    cyc(1);
    check_v(32'(state)); check_v(32'(locked)); check_v(32'(bit_cnt));
    expect_v("t1_lock_999", 2); expect_v("t1_bits999", 999);
    cyc(999);
    check_v(32'(state)); check_v(32'(bit_cnt));
    expect_v("t1_done", 3); expect_v("t1_bits1000", 1000); expect_v("t1_err", 0);
    expect_v("t1_los", 0);  expect_v("t1_tx_valid_done", 0);
    cyc(1);
    check_v(32'(state)); check_v(32'(bit_cnt)); check_v(32'(err_cnt));
    check_v(32'(los)); check_v(32'(tx_valid));
    expect_v("t1_frozen_bits", 1000); expect_v("t1_frozen_state", 3);
    cyc(5);
    check_v(32'(bit_cnt)); check_v(32'(state));

    // Test 2: fresh test from DONE, run forever, three isolated flipped bits.
    // The self-synchronising checker sees each flip three times (taps 28 and 31).
    test_len = '0;
    expect_v("t2_sync", 1); expect_v("t2_bits_clr", 0); expect_v("t2_err_clr", 0);
    pulse_start();
    check_v(32'(state)); check_v(32'(bit_cnt)); check_v(32'(err_cnt));
    expect_v("t2_lock", 2);
    cyc(62);
    check_v(32'(state));
    expect_v("t2_err_first", 1);
    cyc(40); flip_one();
    check_v(32'(err_cnt));
    cyc(40); flip_one();
    cyc(40); flip_one();
    expect_v("t2_state", 2); expect_v("t2_err", 9); expect_v("t2_bits", 163); expect_v("t2_los", 0);
    cyc(40);
    check_v(32'(state)); check_v(32'(err_cnt)); check_v(32'(bit_cnt)); check_v(32'(los));

    // Test 3: eight consecutive bad bits drop lock, then relock
    expect_v("t3_lock_7", 2); expect_v("t3_err_7", 16);
    flip = 1'b1;
    cyc(7);
    check_v(32'(state)); check_v(32'(err_cnt));
    expect_v("t3_sync", 1); expect_v("t3_los", 1); expect_v("t3_locked", 0);
    expect_v("t3_err", 17); expect_v("t3_bits", 171);
    cyc(1);
    flip = 1'b0;
    check_v(32'(state)); check_v(32'(los)); check_v(32'(locked));
    check_v(32'(err_cnt)); check_v(32'(bit_cnt));
    expect_v("t3_sync_61", 1); expect_v("t3_bits_held", 171);
    cyc(61);
    check_v(32'(state)); check_v(32'(bit_cnt));
    expect_v("t3_relock", 2);
    cyc(1);
    check_v(32'(state));
    expect_v("t3_bits_after", 181); expect_v("t3_err_after", 17);
    cyc(10);
    check_v(32'(bit_cnt)); check_v(32'(err_cnt));

    // Test 4: stop and start together in LOCK -> IDLE with counters held
    expect_v("t4_idle", 0); expect_v("t4_tx_valid", 0); expect_v("t4_locked", 0);
    expect_v("t4_bits", 181); expect_v("t4_err", 17);
    stop = 1'b1; start = 1'b1;
    cyc(1);
    stop = 1'b0; start = 1'b0;
    check_v(32'(state)); check_v(32'(tx_valid)); check_v(32'(locked));
    check_v(32'(bit_cnt)); check_v(32'(err_cnt));
    expect_v("t4_idle_hold", 0); expect_v("t4_bits_hold", 181);
    cyc(3);
    check_v(32'(state)); check_v(32'(bit_cnt));

    // Test 5: asynchronous reset in the middle of LOCK
    expect_v("t5_sync", 1); expect_v("t5_bits_clr", 0); expect_v("t5_err_clr", 0); expect_v("t5_los_clr", 0);
    pulse_start();
    check_v(32'(state)); check_v(32'(bit_cnt)); check_v(32'(err_cnt)); check_v(32'(los));
    expect_v("t5_lock", 2); expect_v("t5_err1", 1);
    cyc(62);
    check_v(32'(state));
    cyc(5); flip_one();
    check_v(32'(err_cnt));
    cyc(2);
    expect_v("t5_rst_state", 0); expect_v("t5_rst_err", 0); expect_v("t5_rst_bits", 0);
    expect_v("t5_rst_tx_bit", 0); expect_v("t5_rst_tx_valid", 0); expect_v("t5_rst_locked", 0);
    #2;
    rst_n = 1'b1;
    #1;
    check_v(32'(state)); check_v(32'(err_cnt)); check_v(32'(bit_cnt));
    check_v(32'(tx_bit)); check_v(32'(tx_valid)); check_v(32'(locked));
    @(negedge clk);
    rst_n = 1'b0;
    cyc(1);

    // Test 6: error injection (inert when the feature is not built)
    expect_v("t6_idle_tx_bit", 0); expect_v("t6_idle_state", 0);
`ifdef ERR_INJECT_EN
    inject = 1'b1;
    cyc(1);
    inject = 1'b0;
`else
    cyc(1);
`endif
    check_v(32'(tx_bit)); check_v(32'(state));
    expect_v("t6_lock", 2);
    pulse_start();
    cyc(62);
    check_v(32'(state));
    cyc(5);
    expect_v("t6_err_2cyc", INJ);
`ifdef ERR_INJECT_EN
    inject = 1'b1;
    cyc(1);
    inject = 1'b0;
`else
    cyc(1);
`endif
    cyc(1);
    check_v(32'(err_cnt));
    expect_v("t6_err_echo", 3 * INJ); expect_v("t6_still_lock", 2);
    cyc(40);
    check_v(32'(err_cnt)); check_v(32'(state));

    // Every queued expectation must have been consumed
    n_tests++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
